// File: rtl/io_pkg.sv
// io_pkg: shared definitions for the I/O controller.
//   - FSM state encoding for io_ctrl
//   - default values for the DATA_W / N_PORTS / TIMEOUT parameters
//   - transfer direction constants
//   - port index width helper
package io_pkg;

  localparam int unsigned DataWDefault   = 16;
  localparam int unsigned NPortsDefault  = 4;
  localparam int unsigned TimeoutDefault = 255;

  // Transfer direction, also the value driven on dev_we during REQ.
  localparam logic DIR_IN  = 1'b0;
  localparam logic DIR_OUT = 1'b1;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StReq     = 2'd1,
    StRelease = 2'd2,
    StDone    = 2'd3
  } io_state_e;

  // Port index width; a single-port build still needs a 1-bit select.
  function automatic int unsigned port_w(int unsigned n_ports);
    return (n_ports > 1) ? $clog2(n_ports) : 1;
  endfunction

endpackage

// File: rtl/io_timer.sv
// io_timer: saturating cycle counter guarding one handshake phase.
//   clk_i      system clock
//   reset_i    synchronous active-high reset
//   clear_i    restart the count at zero (wins over enable_i)
//   enable_i   count this cycle
//   expired_o  high while enabled in the cycle that brings the count to TIMEOUT
module io_timer
  import io_pkg::*;
#(
  parameter int unsigned TIMEOUT = TimeoutDefault
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  // A TIMEOUT of 0 would give a zero-width counter; treat it as 1.
  localparam int unsigned Limit = (TIMEOUT > 0) ? TIMEOUT : 1;
  localparam int unsigned CntW  = $clog2(Limit + 1);

  localparam logic [CntW-1:0] CntMax  = CntW'(Limit);
  localparam logic [CntW-1:0] CntLast = CntW'(Limit - 1);

  logic [CntW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i && (count_q != CntMax)) begin
      count_d = count_q + 1'b1;
    end
  end

  // count_q holds the cycles already spent in the phase, so the current cycle
  // is the last one allowed once count_q has reached TIMEOUT-1.
  assign expired_o = enable_i && (count_q >= CntLast);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/io_ctrl.sv
// io_ctrl: bridges the CPU IN/OUT instructions to N_PORTS peripherals using a
// one-hot 4-phase req/ack handshake.
//   clk_i, reset_i      system clock, synchronous active-high reset
//   cpu_in_req_i        CPU requests a read (IN)
//   cpu_out_req_i       CPU requests a write (OUT)
//   cpu_port_i          selected peripheral port
//   cpu_wdata_i         OUT data, latched when the request is accepted
//   cpu_rdata_o         IN data, held until the next IN completes
//   cpu_stall_o         freezes the CPU control unit while high
//   cpu_done_o          one-cycle completion pulse
//   cpu_err_o           timeout / protocol error, valid with cpu_done_o
//   dev_req_o           one-hot request, one bit per port
//   dev_we_o            1 = write, 0 = read, valid while dev_req_o is non-zero
//   dev_wdata_o         shared write bus
//   dev_rdata_i         shared read bus, sampled with the selected ack
//   dev_ack_i           per-port acknowledge
module io_ctrl
  import io_pkg::*;
#(
  parameter int unsigned DATA_W  = DataWDefault,
  parameter int unsigned N_PORTS = NPortsDefault,
  parameter int unsigned TIMEOUT = TimeoutDefault,
  localparam int unsigned PortW  = port_w(N_PORTS)
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               cpu_in_req_i,
  input  logic               cpu_out_req_i,
  input  logic [PortW-1:0]   cpu_port_i,
  input  logic [DATA_W-1:0]  cpu_wdata_i,
  output logic [DATA_W-1:0]  cpu_rdata_o,
  output logic               cpu_stall_o,
  output logic               cpu_done_o,
  output logic               cpu_err_o,
  output logic [N_PORTS-1:0] dev_req_o,
  output logic               dev_we_o,
  output logic [DATA_W-1:0]  dev_wdata_o,
  input  logic [DATA_W-1:0]  dev_rdata_i,
  input  logic [N_PORTS-1:0] dev_ack_i
);

  io_state_e         state_q, state_d;
  logic [PortW-1:0]  port_q, port_d;
  logic              dir_q, dir_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;

  logic              timer_clear;
  logic              timer_en;
  logic              timer_expired;

  logic [N_PORTS-1:0] sel_oh;
  logic               sel_ack;
  logic               any_req;
  logic               both_req;

  assign any_req  = cpu_in_req_i || cpu_out_req_i;
  assign both_req = cpu_in_req_i && cpu_out_req_i;

  // Decode the latched port; an index beyond N_PORTS selects nothing, so the
  // transfer simply times out instead of driving a non-existent request line.
  always_comb begin
    sel_oh = '0;
    for (int unsigned i = 0; i < N_PORTS; i++) begin
      sel_oh[i] = (port_q == PortW'(i));
    end
  end

  // Only the selected port's ack is ever looked at.
  assign sel_ack = |(dev_ack_i & sel_oh);

  io_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .clear_i   (timer_clear),
    .enable_i  (timer_en),
    .expired_o (timer_expired)
  );

  always_comb begin
    state_d     = state_q;
    port_d      = port_q;
    dir_d       = dir_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    timer_clear = 1'b0;
    timer_en    = 1'b0;

    case (state_q)
      StIdle: begin
        timer_clear = 1'b1;
        if (both_req) begin
          err_d   = 1'b1;
          state_d = StDone;
        end else if (any_req) begin
          port_d  = cpu_port_i;
          dir_d   = cpu_out_req_i ? DIR_OUT : DIR_IN;
          wdata_d = cpu_wdata_i;
          err_d   = 1'b0;
          state_d = StReq;
        end
      end

      StReq: begin
        timer_en = 1'b1;
        if (sel_ack) begin
          if (dir_q == DIR_IN) begin
            rdata_d = dev_rdata_i;
          end
          timer_clear = 1'b1;
          state_d     = StRelease;
        end else if (timer_expired) begin
          err_d = 1'b1;
          if (dir_q == DIR_IN) begin
            rdata_d = '0;
          end
          state_d = StDone;
        end
      end

      StRelease: begin
        timer_en = 1'b1;
        if (!sel_ack) begin
          state_d = StDone;
        end else if (timer_expired) begin
          err_d = 1'b1;
          if (dir_q == DIR_IN) begin
            rdata_d = '0;
          end
          state_d = StDone;
        end
      end

      StDone: begin
        // Requests seen here belong to the instruction just completed.
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State only clears at the reset edge, so every control output is masked by
  // reset directly to keep the CPU and the devices quiet while it is held.
  always_comb begin
    cpu_stall_o = 1'b0;
    cpu_done_o  = 1'b0;
    cpu_err_o   = 1'b0;
    dev_req_o   = '0;
    dev_we_o    = 1'b0;
    if (!reset_i) begin
      unique case (state_q)
        StIdle:    cpu_stall_o = any_req;
        StReq: begin
          cpu_stall_o = 1'b1;
          dev_req_o   = sel_oh;
          dev_we_o    = (dir_q == DIR_OUT);
        end
        StRelease: cpu_stall_o = 1'b1;
        StDone: begin
          cpu_done_o = 1'b1;
          cpu_err_o  = err_q;
        end
      endcase
    end
  end

  assign cpu_rdata_o = rdata_q;
  assign dev_wdata_o = wdata_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= StIdle;
      port_q  <= '0;
      dir_q   <= DIR_IN;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      port_q  <= port_d;
      dir_q   <= dir_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

endmodule
